// File: rtl/prng_step_scheduler_if.sv
// Handshake/bus bundle between the PRNG step scheduler and the LFSR datapath
// plus its two byte consumers. The scheduler drives through the master
// modport; the datapath/consumer side uses the slave modport.
interface prng_step_scheduler_if;
  logic        ena;
  logic        seed_load_req;
  logic [15:0] seed_in;
  logic        lfsr_load;
  logic [15:0] lfsr_seed;
  logic        data_step;
  logic        ctrl_step;
  logic [7:0]  rand_byte;
  logic [1:0]  req;
  logic [1:0]  gnt;
  logic [7:0]  rd_data;
  logic        rd_valid;
  logic [7:0]  display_byte;
  logic        seed_err;

  modport master (
    input  ena, seed_load_req, seed_in, rand_byte, req,
    output lfsr_load, lfsr_seed, data_step, ctrl_step,
           gnt, rd_data, rd_valid, display_byte, seed_err
  );

  modport slave (
    output ena, seed_load_req, seed_in, rand_byte, req,
    input  lfsr_load, lfsr_seed, data_step, ctrl_step,
           gnt, rd_data, rd_valid, display_byte, seed_err
  );
endinterface

// File: rtl/prng_step_scheduler.sv
// Single-clock sequencer for the PRNG datapath. Two prescalers turn clk into
// one-cycle step enables for the data and control LFSRs, a 3-state FSM
// handles seed loading, and a round-robin arbiter hands each freshly stepped
// random byte to at most one of two consumers. The byte shown on the
// 7-segment displays is latched whenever a new byte becomes valid.

// Step-enable prescaler: counts 0..DIV-1 while enabled and pulses step in
// the cycle after the terminal count. clr wins over en.
module prng_prescaler #(
  parameter int DIV   = 4,
  parameter int CNT_W = 24
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic en,
  output logic step
);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(DIV - 1);

  logic [CNT_W-1:0] cnt;

  // Counter and registered step pulse; any pause or reload restarts from 0.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt  <= '0;
      step <= 1'b0;
    end else if (clr) begin
      cnt  <= '0;
      step <= 1'b0;
    end else if (en) begin
      step <= (cnt == LAST);
      cnt  <= (cnt == LAST) ? '0 : cnt + 1'b1;
    end else begin
      step <= 1'b0;
    end
  end
endmodule

module prng_step_scheduler #(
  parameter int DATA_DIV = 10_000_000,
  parameter int CTRL_DIV = 4,
  parameter int CNT_W    = 24
) (
  input  logic                   clk,
  input  logic                   rst_n,
  prng_step_scheduler_if.master  bus
);
  typedef enum logic [1:0] {IDLE, RUN, LOAD} state_t;

  // Data-LFSR XNOR feedback locks up in the all-ones state.
  localparam logic [15:0] LOCKUP = 16'hFFFF;

  state_t     state;
  logic       fresh;     // rand_byte holds a byte no consumer has taken yet
  logic       step_d;    // rand_byte became valid this cycle
  logic       rr;        // requester index that wins a tie
  logic [1:0] steps;     // [0] data, [1] ctrl

  logic       run_go;
  logic       load_go;
  logic       pres_clr;
  logic       grant_go;
  logic       gnt_idx;
  logic       lockup;

  assign run_go   = bus.ena && (state == RUN) && !bus.seed_load_req;
  assign load_go  = bus.ena && (state == RUN) &&  bus.seed_load_req;
  // Pausing, entering a load and the load cycle itself all restart the count.
  assign pres_clr = !bus.ena || load_go || (state == LOAD);
  assign lockup   = (bus.seed_in == LOCKUP);

  // Round-robin pick; a lone requester wins outright, a tie goes to rr.
  always_comb begin
    grant_go = run_go && fresh && (|bus.req);
    gnt_idx  = (bus.req == 2'b11) ? rr : ~bus.req[0];
  end

  genvar i;
  generate
    for (i = 0; i < 2; i++) begin : g_pres
      prng_prescaler #(
        .DIV   (i == 0 ? DATA_DIV : CTRL_DIV),
        .CNT_W (CNT_W)
      ) u_pres (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (pres_clr),
        .en    (run_go),
        .step  (steps[i])
      );
    end
  endgenerate

  assign bus.data_step = steps[0];
  assign bus.ctrl_step = steps[1];

  // Sequencer FSM with registered load/grant/display outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state            <= IDLE;
      fresh            <= 1'b0;
      step_d           <= 1'b0;
      rr               <= 1'b0;
      bus.lfsr_load    <= 1'b0;
      bus.lfsr_seed    <= '0;
      bus.seed_err     <= 1'b0;
      bus.gnt          <= '0;
      bus.rd_data      <= '0;
      bus.rd_valid     <= 1'b0;
      bus.display_byte <= '0;
    end else if (!bus.ena) begin
      // Pause: drop everything in flight, keep display/seed/rd_data.
      state         <= IDLE;
      fresh         <= 1'b0;
      step_d        <= 1'b0;
      bus.lfsr_load <= 1'b0;
      bus.seed_err  <= 1'b0;
      bus.gnt       <= '0;
      bus.rd_valid  <= 1'b0;
    end else begin
      bus.lfsr_load <= 1'b0;
      bus.seed_err  <= 1'b0;
      bus.gnt       <= grant_go ? (gnt_idx ? 2'b10 : 2'b01) : 2'b00;
      bus.rd_valid  <= grant_go;
      step_d        <= bus.data_step;

      if (grant_go) begin
        bus.rd_data <= bus.rand_byte;
        rr          <= ~gnt_idx;
      end

      if (step_d)
        bus.display_byte <= bus.rand_byte;

      unique case (state)
        IDLE: state <= RUN;
        RUN: begin
          if (bus.seed_load_req) begin
            state         <= LOAD;
            bus.lfsr_load <= 1'b1;
            bus.lfsr_seed <= lockup ? 16'h0000 : bus.seed_in;
            bus.seed_err  <= lockup;
          end
        end
        LOAD: begin
          state  <= RUN;
          // The seeded byte appears next cycle; treat it like a fresh step.
          step_d <= 1'b1;
        end
        default: state <= IDLE;
      endcase

      // A reload invalidates the current byte; a new byte beats a grant.
      if (load_go || (state == LOAD))
        fresh <= 1'b0;
      else if (step_d)
        fresh <= 1'b1;
      else if (grant_go)
        fresh <= 1'b0;
    end
  end
endmodule

// File: tb/tb_prng_step_scheduler.sv
// Bench for prng_step_scheduler: directed sequences for step timing, seed
// loading, arbitration and pause/reset corners, then random traffic compared
// each cycle against a cycle-level reference model.
module tb_prng_step_scheduler;
  localparam int DD = 8;
  localparam int CD = 2;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  prng_step_scheduler_if bus();

  prng_step_scheduler #(.DATA_DIV(DD), .CTRL_DIV(CD), .CNT_W(8)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int n_chk = 0;
  int n_err = 0;

  // Reference model: mode 0 idle, 1 run, 2 load; m_edges = edges since RUN entry.
  int          m_mode, m_edges, m_rr;
  bit          m_fresh, m_stepd;
  logic        e_load, e_err, e_ds, e_cs, e_rv;
  logic [15:0] e_seed;
  logic [1:0]  e_gnt;
  logic [7:0]  e_rd, e_disp;

  typedef struct {
    logic [15:0] seed;
    logic [15:0] exp_seed;
    logic        exp_err;
  } seed_vec_t;
  seed_vec_t tbl[5];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_mode = 0; m_edges = 0; m_rr = 0; m_fresh = 0; m_stepd = 0;
    e_load = 0; e_err = 0; e_ds = 0; e_cs = 0; e_rv = 0;
    e_seed = '0; e_gnt = '0; e_rd = '0; e_disp = '0;
  endtask

  // Advance the model over one clock edge using the inputs currently driven.
  task automatic model_step();
    logic ds_now, sd_now, fr_now, granted;
    int   mode_now, pick;
    ds_now = e_ds; sd_now = m_stepd; fr_now = m_fresh; mode_now = m_mode;
    granted = 0; pick = 0;
    e_load = 0; e_err = 0; e_ds = 0; e_cs = 0; e_rv = 0; e_gnt = '0;
    if (!bus.ena) begin
      m_mode = 0; m_edges = 0; m_fresh = 0; m_stepd = 0;
    end else begin
      m_stepd = ds_now;
      if (sd_now) e_disp = bus.rand_byte;
      if (mode_now == 0) begin
        m_mode = 1; m_edges = 0;
      end else if (mode_now == 2) begin
        m_mode = 1; m_edges = 0; m_stepd = 1;
      end else if (bus.seed_load_req) begin
        m_mode = 2; m_edges = 0; e_load = 1;
        e_err  = (bus.seed_in == 16'hFFFF);
        e_seed = e_err ? 16'h0000 : bus.seed_in;
      end else begin
        m_edges++;
        e_ds = (m_edges % DD) == 0;
        e_cs = (m_edges % CD) == 0;
        if (fr_now && bus.req != 2'b00) begin
          pick    = (bus.req == 2'b11) ? m_rr : (bus.req[0] ? 0 : 1);
          granted = 1;
          e_gnt   = (pick == 0) ? 2'b01 : 2'b10;
          e_rd    = bus.rand_byte;
          e_rv    = 1;
          m_rr    = 1 - pick;
        end
      end
      if (mode_now == 2 || (mode_now == 1 && bus.seed_load_req)) m_fresh = 0;
      else if (sd_now) m_fresh = 1;
      else if (granted) m_fresh = 0;
    end
  endtask

  task automatic compare_all();
    chk("lfsr_load",    bus.lfsr_load,    e_load);
    chk("lfsr_seed",    bus.lfsr_seed,    e_seed);
    chk("seed_err",     bus.seed_err,     e_err);
    chk("data_step",    bus.data_step,    e_ds);
    chk("ctrl_step",    bus.ctrl_step,    e_cs);
    chk("gnt",          bus.gnt,          e_gnt);
    chk("rd_data",      bus.rd_data,      e_rd);
    chk("rd_valid",     bus.rd_valid,     e_rv);
    chk("display_byte", bus.display_byte, e_disp);
  endtask

  task automatic cyc(input logic e, input logic sl, input logic [15:0] sd,
                     input logic [7:0] rb, input logic [1:0] rq);
    bus.ena = e; bus.seed_load_req = sl; bus.seed_in = sd;
    bus.rand_byte = rb; bus.req = rq;
    model_step();
    @(posedge clk); #1;
    compare_all();
  endtask

  task automatic do_reset();
    bus.ena = 0; bus.seed_load_req = 0; bus.seed_in = '0;
    bus.rand_byte = '0; bus.req = '0;
    rst_n = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    compare_all();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] vals[3];
    int         ngnt;
    vals[0] = 8'hA5; vals[1] = 8'h3C; vals[2] = 8'h7E;
    tbl[0] = '{16'h1234, 16'h1234, 1'b0};
    tbl[1] = '{16'hFFFF, 16'h0000, 1'b1};
    tbl[2] = '{16'h0000, 16'h0000, 1'b0};
    tbl[3] = '{16'hFFFE, 16'hFFFE, 1'b0};
    tbl[4] = '{16'h8001, 16'h8001, 1'b0};

    // Reset state and step cadence with no requests.
    do_reset();
    chk("rst_display", bus.display_byte, 8'h00);
    cyc(1, 0, 0, 8'h00, 2'b00);
    for (int n = 1; n <= 24; n++) begin
      cyc(1, 0, 0, 8'($urandom), 2'b00);
      chk("step_data_cadence", bus.data_step, (n % 8) == 0);
      chk("step_ctrl_cadence", bus.ctrl_step, (n % 2) == 0);
      chk("step_no_gnt", bus.gnt, 2'b00);
    end

    // Both requesters held across three fresh bytes.
    do_reset();
    cyc(1, 0, 0, 8'h00, 2'b00);
    ngnt = 0;
    for (int n = 1; n <= 32; n++) begin
      cyc(1, 0, 0, (n >= 10) ? vals[(n - 10) / 8] : 8'($urandom), 2'b11);
      if (bus.gnt != 2'b00) ngnt++;
      chk("arb_gnt", bus.gnt, (n == 11 || n == 27) ? 2'b01 : (n == 19) ? 2'b10 : 2'b00);
      if (n == 11) chk("arb_rd0", bus.rd_data, 8'hA5);
      if (n == 19) chk("arb_rd1", bus.rd_data, 8'h3C);
      if (n == 27) chk("arb_rd2", bus.rd_data, 8'h7E);
      if (n == 10) chk("arb_disp", bus.display_byte, 8'hA5);
    end
    chk("arb_gnt_count", ngnt, 3);
    // Seed load and request together: load wins, no grant.
    cyc(1, 0, 0, 8'h11, 2'b00);
    cyc(1, 0, 0, 8'h22, 2'b00);
    cyc(1, 1, 16'hABCD, 8'h33, 2'b01);
    chk("ldreq_load", bus.lfsr_load, 1'b1);
    chk("ldreq_gnt", bus.gnt, 2'b00);
    cyc(1, 0, 0, 8'h44, 2'b01);
    chk("ldreq_gnt2", bus.gnt, 2'b00);
    cyc(1, 0, 0, 8'h55, 2'b01);
    chk("ldreq_disp", bus.display_byte, 8'h55);
    cyc(1, 0, 0, 8'h66, 2'b01);
    chk("ldreq_gnt_after", bus.gnt, 2'b01);
    chk("ldreq_rd", bus.rd_data, 8'h66);
    // Requester 0 keeps asking right after its grant.
    for (int k = 1; k <= 9; k++) begin
      cyc(1, 0, 0, 8'h77, 2'b01);
      chk("regrant_gnt", bus.gnt, (k == 9) ? 2'b01 : 2'b00);
    end

    // Seed-load table.
    for (int t = 0; t < 5; t++) begin
      do_reset();
      cyc(1, 0, 0, 8'h00, 2'b00);
      for (int n = 1; n <= 3; n++) cyc(1, 0, 0, 8'h00, 2'b00);
      cyc(1, 1, tbl[t].seed, 8'h00, 2'b00);
      chk("seed_load", bus.lfsr_load, 1'b1);
      chk("seed_value", bus.lfsr_seed, tbl[t].exp_seed);
      chk("seed_err", bus.seed_err, tbl[t].exp_err);
      chk("seed_no_dstep", bus.data_step, 1'b0);
      chk("seed_no_cstep", bus.ctrl_step, 1'b0);
      cyc(1, 0, 0, 8'h00, 2'b00);
      chk("seed_load_end", bus.lfsr_load, 1'b0);
      chk("seed_err_end", bus.seed_err, 1'b0);
      cyc(1, 0, 0, 8'(8'hC0 + t), 2'b00);
      chk("seed_disp", bus.display_byte, 8'(8'hC0 + t));
      for (int k = 3; k <= 9; k++) begin
        cyc(1, 0, 0, 8'h00, 2'b00);
        chk("seed_next_step", bus.data_step, k == 9);
      end
    end

    // Pause just before a step is due; display holds, counts restart.
    do_reset();
    cyc(1, 0, 0, 8'h00, 2'b00);
    for (int n = 1; n <= 15; n++) cyc(1, 0, 0, (n == 10) ? 8'h5A : 8'h00, 2'b11);
    for (int k = 0; k < 3; k++) begin
      cyc(0, 0, 0, 8'hEE, 2'b11);
      chk("pause_dstep", bus.data_step, 1'b0);
      chk("pause_cstep", bus.ctrl_step, 1'b0);
      chk("pause_gnt", bus.gnt, 2'b00);
      chk("pause_disp", bus.display_byte, 8'h5A);
    end
    cyc(1, 0, 0, 8'h00, 2'b00);
    for (int k = 1; k <= 8; k++) begin
      cyc(1, 0, 0, 8'h00, 2'b00);
      chk("resume_step", bus.data_step, k == 8);
    end

    // Reset asserted during the load cycle.
    do_reset();
    cyc(1, 0, 0, 8'h00, 2'b00);
    for (int n = 1; n <= 12; n++) cyc(1, 0, 0, (n == 10) ? 8'hC3 : 8'h00, 2'b00);
    cyc(1, 1, 16'h1234, 8'h00, 2'b00);
    #1 rst_n = 1'b0;
    #1;
    chk("rstload_load", bus.lfsr_load, 1'b0);
    chk("rstload_seed", bus.lfsr_seed, 16'h0000);
    chk("rstload_disp", bus.display_byte, 8'h00);
    do_reset();
    cyc(1, 0, 0, 8'h00, 2'b00);
    for (int k = 1; k <= 8; k++) begin
      cyc(1, 0, 0, 8'h00, 2'b00);
      chk("rstload_restart", bus.data_step, k == 8);
    end

    // Random traffic against the model.
    do_reset();
    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(0, 599) == 0) do_reset();
      cyc(($urandom_range(0, 31) != 0), ($urandom_range(0, 19) == 0),
          ($urandom_range(0, 3) == 0) ? 16'hFFFF : 16'($urandom),
          8'($urandom), 2'($urandom));
    end

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule
